// File: rtl/hub_arbiter_if.sv
// Cog/hub-memory bus bundle for hub_arbiter.
// master: arbiter side (drives hub_mem inputs, slot, ack, q).
// slave : cog array plus hub_mem side.
interface hub_arbiter_if #(
   parameter int unsigned COGS = 8,
   parameter int unsigned AW   = 14
);
   logic                 ena_bus;
   logic [COGS-1:0]      cog_ena;
   logic [COGS-1:0]      req;
   logic [COGS-1:0]      req_w;
   logic [4*COGS-1:0]    req_wb;
   logic [AW*COGS-1:0]   req_a;
   logic [32*COGS-1:0]   req_d;
   logic                 mem_w;
   logic [3:0]           mem_wb;
   logic [AW-1:0]        mem_a;
   logic [31:0]          mem_d;
   logic [31:0]          mem_q;
   logic [2:0]           slot;
   logic [COGS-1:0]      ack;
   logic [31:0]          q;

   modport master (
      input  ena_bus, cog_ena, req, req_w, req_wb, req_a, req_d, mem_q,
      output mem_w, mem_wb, mem_a, mem_d, slot, ack, q
   );

   modport slave (
      output ena_bus, cog_ena, req, req_w, req_wb, req_a, req_d, mem_q,
      input  mem_w, mem_wb, mem_a, mem_d, slot, ack, q
   );
endinterface

// File: rtl/hub_arbiter.sv
// Round-robin hub slot scheduler sharing hub_mem among 8 cogs.
// Optional macro HUB_SKIP_IDLE_EN: slot skips cogs whose cog_ena bit is clear.
module hub_arbiter #(
   parameter int unsigned COGS = 8,
   parameter int unsigned AW   = 14
) (
   input  logic          clk_cog,
   input  logic          res,
   hub_arbiter_if.master bus
);
   localparam int unsigned SW = 3;

   logic [SW-1:0]   slot_r;
   logic [SW-1:0]   slot_nxt;
   logic [COGS-1:0] ack_r;
   logic            grant;

`ifdef HUB_SKIP_IDLE_EN
   logic [SW-1:0]   idx;
   logic            found;

   // Next enabled cog above the current one; i=8 wraps back onto the current slot.
   always_comb begin
      slot_nxt = slot_r;
      idx      = slot_r;
      found    = 1'b0;
      for (int unsigned i = 1; i <= 8; i++) begin
         idx = SW'(slot_r + SW'(i));
         if (!found && bus.cog_ena[idx]) begin
            slot_nxt = idx;
            found    = 1'b1;
         end
      end
   end

   assign grant = bus.req[slot_r] & bus.cog_ena[slot_r] & bus.ena_bus & ~res;
`else
   logic unused_cog_ena;

   // Strict rotation; cog_ena is not consulted in this build.
   always_comb begin
      slot_nxt       = SW'(slot_r + SW'(1));
      unused_cog_ena = ^bus.cog_ena;
   end

   assign grant = bus.req[slot_r] & bus.ena_bus & ~res;
`endif

   // Slot counter and one-hot acknowledge, both advanced only on bus-enable edges.
   always_ff @(posedge clk_cog or posedge res) begin
      if (res) begin
         slot_r <= '0;
         ack_r  <= '0;
      end else if (bus.ena_bus) begin
         slot_r <= slot_nxt;
         ack_r  <= grant ? (COGS'(1) << slot_r) : '0;
      end
   end

   // Owning cog's fields go to hub_mem; write strobe only on a real grant.
   always_comb begin
      bus.mem_a  = bus.req_a[AW*int'(slot_r) +: AW];
      bus.mem_d  = bus.req_d[32*int'(slot_r) +: 32];
      bus.mem_wb = bus.req_wb[4*int'(slot_r) +: 4];
      bus.mem_w  = grant & bus.req_w[slot_r];
      bus.slot   = slot_r;
      bus.ack    = ack_r;
      bus.q      = bus.mem_q;
   end
endmodule

// File: tb/tb_hub_arbiter.sv
// Directed bench for hub_arbiter with a read-before-write hub_mem model.
module tb_hub_arbiter;
   localparam int unsigned AW = 14;

   typedef struct {
      logic        ena;
      logic [7:0]  req;
      logic [7:0]  req_w;
      logic [2:0]  slot;
      logic        mem_w;
      logic [7:0]  ack;
      logic        chk_q;
      logic [31:0] q;
   } vec_t;

   logic clk_cog;
   logic res;
   int   checks;
   int   errors;
   logic [31:0] mem [0:(1<<AW)-1];

   hub_arbiter_if #(.COGS(8), .AW(AW)) tif ();

   hub_arbiter #(.COGS(8), .AW(AW)) u_dut (
      .clk_cog (clk_cog),
      .res     (res),
      .bus     (tif.master)
   );

   initial begin
      clk_cog = 1'b0;
      forever #5 clk_cog = ~clk_cog;
   end

   // hub_mem model: registered read, read-before-write, byte enables
   always @(posedge clk_cog) begin
      if (tif.ena_bus) begin
         tif.mem_q <= mem[tif.mem_a];
         if (tif.mem_w)
            for (int b = 0; b < 4; b++)
               if (tif.mem_wb[b]) mem[tif.mem_a][8*b +: 8] <= tif.mem_d[8*b +: 8];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic set_cog(input int c, input logic [3:0] wb, input logic [AW-1:0] a,
                          input logic [31:0] d);
      tif.req_wb[4*c +: 4] = wb;
      tif.req_a[AW*c +: AW] = a;
      tif.req_d[32*c +: 32] = d;
   endtask

   // One access by cog c with continuous ena_bus; returns q seen during ack.
   task automatic access(input int c, input logic w, input logic [3:0] wb,
                         input logic [AW-1:0] a, input logic [31:0] d,
                         output logic [31:0] qv);
      bit done;
      done = 0;
      qv   = '0;
      set_cog(c, wb, a, d);
      tif.req      = 8'(1) << c;
      tif.req_w    = w ? (8'(1) << c) : 8'h00;
      tif.ena_bus  = 1'b1;
      for (int n = 0; n < 12 && !done; n++) begin
         @(posedge clk_cog);
         @(negedge clk_cog);
         #1;
         chk("mem_w_foreign_slot", 32'(tif.mem_w && (tif.slot != 3'(c))), 32'd0);
         if (tif.ack != 8'h00) begin
            chk("access_ack", 32'(tif.ack), 32'(8'(1) << c));
            qv      = tif.q;
            done    = 1;
            tif.req = 8'h00;
            tif.req_w = 8'h00;
         end
      end
      if (!done) chk("access_timeout", 32'd0, 32'd1);
   endtask

   task automatic reset_pulse();
      @(negedge clk_cog);
      res = 1'b1;
      #1;
      chk("rst_slot", 32'(tif.slot), 32'd0);
      chk("rst_ack", 32'(tif.ack), 32'd0);
      @(negedge clk_cog);
      res = 1'b0;
      #1;
   endtask

   initial begin
      vec_t vt [16];
      logic [31:0] qv;
      int served [8];

      checks = 0;
      errors = 0;

      // ena, req, req_w, slot, mem_w, ack, chk_q, q
      vt[0]  = '{1'b1, 8'h08, 8'h08, 3'd0, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[1]  = '{1'b0, 8'h08, 8'h08, 3'd1, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[2]  = '{1'b1, 8'h08, 8'h08, 3'd1, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[3]  = '{1'b0, 8'h08, 8'h08, 3'd2, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[4]  = '{1'b1, 8'h08, 8'h08, 3'd2, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[5]  = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[6]  = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 8'h00, 1'b0, 32'h0};
      vt[7]  = '{1'b0, 8'h08, 8'h08, 3'd4, 1'b0, 8'h08, 1'b0, 32'h0};
      vt[8]  = '{1'b1, 8'h00, 8'h00, 3'd4, 1'b0, 8'h08, 1'b0, 32'h0};
      vt[9]  = '{1'b0, 8'h20, 8'h00, 3'd5, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[10] = '{1'b1, 8'h20, 8'h00, 3'd5, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[11] = '{1'b0, 8'h00, 8'h00, 3'd6, 1'b0, 8'h20, 1'b1, 32'hDEADBEEF};
      vt[12] = '{1'b1, 8'h00, 8'h00, 3'd6, 1'b0, 8'h20, 1'b1, 32'hDEADBEEF};
      vt[13] = '{1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[14] = '{1'b1, 8'h00, 8'h00, 3'd7, 1'b0, 8'h00, 1'b0, 32'h0};
      vt[15] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 32'h0};

      for (int c = 0; c < 8; c++) set_cog(c, 4'hF, AW'(32'h100 + c), 32'(c));
      set_cog(3, 4'hF, AW'(32'h0010), 32'hDEADBEEF);
      set_cog(5, 4'hF, AW'(32'h0010), 32'h0);
      tif.cog_ena = 8'hFF;
      tif.mem_q   = '0;

      // Reset held with every cog requesting writes and ena_bus toggling
      res         = 1'b1;
      tif.req     = 8'hFF;
      tif.req_w   = 8'hFF;
      tif.ena_bus = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_cog);
         tif.ena_bus = ~tif.ena_bus;
         #1;
         chk("reset_slot", 32'(tif.slot), 32'd0);
         chk("reset_ack", 32'(tif.ack), 32'd0);
         chk("reset_mem_w", 32'(tif.mem_w), 32'd0);
      end

      // Table: release, rotation at ena=clk/2, cog 3 write, cog 5 read-back
      @(negedge clk_cog);
      res = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tif.ena_bus = vt[i].ena;
         tif.req     = vt[i].req;
         tif.req_w   = vt[i].req_w;
         #1;
         chk($sformatf("vec%0d_slot", i), 32'(tif.slot), 32'(vt[i].slot));
         chk($sformatf("vec%0d_mem_w", i), 32'(tif.mem_w), 32'(vt[i].mem_w));
         chk($sformatf("vec%0d_ack", i), 32'(tif.ack), 32'(vt[i].ack));
         if (vt[i].chk_q) chk($sformatf("vec%0d_q", i), tif.q, vt[i].q);
         @(negedge clk_cog);
      end

      // Rotation: 16 ena pulses, slot holds on ena_bus=0 cycles
      for (int p = 0; p < 16; p++) begin
         tif.ena_bus = 1'b1;
         #1;
         chk("rot_slot_on", 32'(tif.slot), 32'(p % 8));
         @(negedge clk_cog);
         tif.ena_bus = 1'b0;
         #1;
         chk("rot_slot_hold", 32'(tif.slot), 32'((p + 1) % 8));
         @(negedge clk_cog);
      end

      // Byte write from cog 3, read back by cog 5
      access(3, 1'b1, 4'h1, AW'(32'h0010), 32'h000000AA, qv);
      chk("bytewr_old_q", qv, 32'hDEADBEEF);
      access(5, 1'b0, 4'hF, AW'(32'h0010), 32'h0, qv);
      chk("byte_readback", qv, 32'hDEADBEAA);

      // Contention: all cogs request continuously
      tif.ena_bus = 1'b1;
      tif.req     = 8'hFF;
      tif.req_w   = 8'h00;
      reset_pulse();
      for (int c = 0; c < 8; c++) served[c] = 0;
      for (int k = 0; k <= 24; k++) begin
         chk("cont_slot", 32'(tif.slot), 32'(k % 8));
         chk("cont_ack", 32'(tif.ack), (k == 0) ? 32'd0 : 32'(8'(1) << ((k - 1) % 8)));
         for (int c = 0; c < 8; c++) if (tif.ack[c]) served[c]++;
         @(negedge clk_cog);
         #1;
      end
      for (int c = 0; c < 8; c++) chk($sformatf("cont_served%0d", c), 32'(served[c]), 32'd3);

`ifdef HUB_SKIP_IDLE_EN
      // Only cogs 0,2,5 enabled; cog 1 requests but is never served
      tif.req     = 8'h02;
      tif.cog_ena = 8'h25;
      reset_pulse();
      for (int k = 0; k < 5; k++) begin
         chk("skip_slot", 32'(tif.slot), (k % 3 == 0) ? 32'd0 : (k % 3 == 1) ? 32'd2 : 32'd5);
         chk("skip_ack", 32'(tif.ack), 32'd0);
         @(negedge clk_cog);
         #1;
      end
      // No enabled cogs: slot frozen, no grants
      tif.cog_ena = 8'h00;
      tif.req     = 8'hFF;
      tif.req_w   = 8'hFF;
      #1;
      chk("frozen_mem_w", 32'(tif.mem_w), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_cog);
         #1;
         chk("frozen_slot", 32'(tif.slot), 32'd5);
         chk("frozen_ack", 32'(tif.ack), 32'd0);
      end
`else
      // cog_ena ignored: strict rotation and cog 1 still served
      tif.req     = 8'h02;
      tif.req_w   = 8'h00;
      tif.cog_ena = 8'h00;
      reset_pulse();
      for (int k = 0; k < 4; k++) begin
         chk("noskip_slot", 32'(tif.slot), 32'(k));
         chk("noskip_ack", 32'(tif.ack), (k == 2) ? 32'h02 : 32'd0);
         @(negedge clk_cog);
         #1;
      end
`endif

      tif.req     = 8'h00;
      tif.ena_bus = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
